// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory req/ack bus between fetch_stage and imem
// Purpose: carries one outstanding fetch at a time; the address is held stable until ack.
// Ports (signals):
//   imem_req   master->slave  fetch request
//   imem_addr  master->slave  word-aligned fetch address
//   imem_ack   slave->master  imem_rdata valid this cycle (may coincide with the first req cycle)
//   imem_rdata slave->master  instruction word
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS IF stage: PC, imem req/ack port, hold buffer and IF/ID register
// Purpose: fetches sequentially from RESET_PC, obeys hazard-unit pc_ld / IF_ID_write / flush,
//          parks an ack that arrives during a stall in a one-entry hold buffer, and discards
//          the in-flight fetch when a redirect arrives before its ack.
// Optional: define FETCH_PERF_CNT_EN to add perf_fetched / perf_dropped / perf_stall_cycles.
// Ports:
//   clk, rst (sync, active low)
//   pc_ld, IF_ID_write, flush        hazard-unit controls
//   jump, branch_target, jump_target redirect target select and values
//   imem                             fetch_stage_if master (req/addr/ack/rdata)
//   IF_ID_instr, IF_ID_pc_plus4, IF_ID_valid   IF/ID pipeline register
//   fetch_busy                       no instruction deliverable this cycle
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pc_ld,
    input  logic                 IF_ID_write,
    input  logic                 flush,
    input  logic                 jump,
    input  logic [31:0]          branch_target,
    input  logic [31:0]          jump_target,
    fetch_stage_if.master        imem,
    output logic [31:0]          IF_ID_instr,
    output logic [31:0]          IF_ID_pc_plus4,
    output logic                 IF_ID_valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]          perf_fetched,
    output logic [31:0]          perf_dropped,
    output logic [31:0]          perf_stall_cycles,
`endif
    output logic                 fetch_busy
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    logic [31:0] tgt;
    logic        adv;
    logic        kill;
    logic        bubble;

    assign tgt = jump ? jump_target : branch_target;
    assign adv = IF_ID_write & pc_ld;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            req_addr_q    <= RESET_PC;
            redirect_pc_q <= RESET_PC;
            buf_q         <= 32'h0;
            instr_q       <= NOP_INSTR;
            pc4_q         <= 32'h0;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_addr_q    <= req_addr_d;
            redirect_pc_q <= redirect_pc_d;
            buf_q         <= buf_d;
            instr_q       <= instr_d;
            pc4_q         <= pc4_d;
            valid_q       <= valid_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d       = state_q;
        req_addr_d    = req_addr_q;
        redirect_pc_d = redirect_pc_q;
        buf_d         = buf_q;
        instr_d       = instr_q;
        pc4_d         = pc4_q;
        valid_d       = valid_q;
        kill          = 1'b0;
        bubble        = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (flush) begin
                    kill       = 1'b1;
                    req_addr_d = tgt;
                end else if (IF_ID_write) begin
                    bubble = 1'b1;
                end
            end
            REQ: begin
                if (flush) begin
                    kill = 1'b1;
                    if (imem.imem_ack) begin
                        req_addr_d = tgt;
                    end else begin
                        // Old request is still outstanding; remember where to go once it retires.
                        redirect_pc_d = tgt;
                        state_d       = DROP;
                    end
                end else if (imem.imem_ack) begin
                    if (adv) begin
                        instr_d    = imem.imem_rdata;
                        pc4_d      = req_addr_q + 32'd4;
                        valid_d    = 1'b1;
                        req_addr_d = req_addr_q + 32'd4;
                    end else begin
                        buf_d   = imem.imem_rdata;
                        state_d = HOLD;
                    end
                end else if (IF_ID_write) begin
                    bubble = 1'b1;
                end
            end
            HOLD: begin
                if (flush) begin
                    kill       = 1'b1;
                    req_addr_d = tgt;
                    state_d    = REQ;
                end else if (adv) begin
                    instr_d    = buf_q;
                    pc4_d      = req_addr_q + 32'd4;
                    valid_d    = 1'b1;
                    req_addr_d = req_addr_q + 32'd4;
                    state_d    = REQ;
                end
            end
            default: begin // DROP
                if (flush) begin
                    kill          = 1'b1;
                    redirect_pc_d = tgt;
                end else if (IF_ID_write) begin
                    bubble = 1'b1;
                end
                if (imem.imem_ack) begin
                    req_addr_d = flush ? tgt : redirect_pc_q;
                    state_d    = REQ;
                end
            end
        endcase

        if (kill || bubble) begin
            instr_d = NOP_INSTR;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
        end
    end

    // Outputs
    always_comb begin
        imem.imem_req = (state_q == REQ) || (state_q == DROP);
        fetch_busy    = (state_q == IDLE) || (state_q == DROP) ||
                        ((state_q == REQ) && !imem.imem_ack);
    end

    assign imem.imem_addr = req_addr_q;
    assign IF_ID_instr    = instr_q;
    assign IF_ID_pc_plus4 = pc4_q;
    assign IF_ID_valid    = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q, fetched_d;
    logic [31:0] dropped_q, dropped_d;
    logic [31:0] stall_q, stall_d;
    logic        fetch_ev, drop_ev, stall_ev;

    assign fetch_ev = !flush && adv &&
                      (((state_q == REQ) && imem.imem_ack) || (state_q == HOLD));
    assign drop_ev  = ((state_q == REQ) && imem.imem_ack && flush) ||
                      ((state_q == DROP) && imem.imem_ack) ||
                      ((state_q == HOLD) && flush);
    assign stall_ev = !flush && !adv;

    always_comb begin
        fetched_d = fetched_q;
        dropped_d = dropped_q;
        stall_d   = stall_q;
        if (fetch_ev && (fetched_q != 32'hFFFF_FFFF)) fetched_d = fetched_q + 32'd1;
        if (drop_ev  && (dropped_q != 32'hFFFF_FFFF)) dropped_d = dropped_q + 32'd1;
        if (stall_ev && (stall_q   != 32'hFFFF_FFFF)) stall_d   = stall_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetched_q <= 32'h0;
            dropped_q <= 32'h0;
            stall_q   <= 32'h0;
        end else begin
            fetched_q <= fetched_d;
            dropped_q <= dropped_d;
            stall_q   <= stall_d;
        end
    end

    assign perf_fetched      = fetched_q;
    assign perf_dropped      = dropped_q;
    assign perf_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_ld;
    logic        IF_ID_write;
    logic        flush;
    logic        jump;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] IF_ID_instr;
    logic [31:0] IF_ID_pc_plus4;
    logic        IF_ID_valid;
    logic        fetch_busy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
    logic [31:0] perf_stall_cycles;
`endif

    int errors = 0;
    int checks = 0;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_ld          (pc_ld),
        .IF_ID_write    (IF_ID_write),
        .flush          (flush),
        .jump           (jump),
        .branch_target  (branch_target),
        .jump_target    (jump_target),
        .imem           (bus),
        .IF_ID_instr    (IF_ID_instr),
        .IF_ID_pc_plus4 (IF_ID_pc_plus4),
        .IF_ID_valid    (IF_ID_valid),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched      (perf_fetched),
        .perf_dropped      (perf_dropped),
        .perf_stall_cycles (perf_stall_cycles),
`endif
        .fetch_busy     (fetch_busy)
    );

    always #5 clk = ~clk;

    // imem model: word at address a is a + 0x100; latency either random or manual.
    logic [1:0]  lat_cnt = 2'd0;
    int unsigned lat_lo = 0, lat_hi = 0;
    logic        man_mode = 1'b0, man_ack = 1'b0;

    assign bus.imem_ack   = bus.imem_req && (man_mode ? man_ack : (lat_cnt == 2'd0));
    assign bus.imem_rdata = bus.imem_addr + 32'h100;

    always @(posedge clk) begin
        if (!bus.imem_req || bus.imem_ack)
            lat_cnt <= 2'($urandom_range(lat_hi, lat_lo));
        else if (lat_cnt != 2'd0)
            lat_cnt <= lat_cnt - 2'd1;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'h100;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; pc_ld = 1'b1; IF_ID_write = 1'b1; flush = 1'b0;
        tick(); tick();
        chk("rst_valid", 32'(IF_ID_valid), 32'd0);
        chk("rst_instr", IF_ID_instr, 32'h0);
        chk("rst_req",   32'(bus.imem_req), 32'd0);
        chk("rst_busy",  32'(fetch_busy), 32'd1);
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Random-phase scoreboard state
    logic [31:0] exp_next;
    logic [31:0] snap_instr, snap_pc4;
    logic        snap_valid;
    logic        a_flush, a_write;
    logic [31:0] a_tgt;
    logic        p_req, p_ack;
    logic [31:0] p_addr;
    int          deliveries;

    initial begin
        rst = 1'b0; pc_ld = 1'b1; IF_ID_write = 1'b1; flush = 1'b0;
        jump = 1'b0; branch_target = 32'h0; jump_target = 32'h0;

        // Zero-wait imem, back-to-back fetch
        lat_lo = 0; lat_hi = 0;
        do_reset();
        tick();
        chk("t1_req",  32'(bus.imem_req), 32'd1);
        chk("t1_addr", bus.imem_addr, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t1_valid", 32'(IF_ID_valid), 32'd1);
            chk("t1_pc4",   IF_ID_pc_plus4, 32'(4 * (k + 1)));
            chk("t1_instr", IF_ID_instr, 32'h100 + 32'(4 * k));
        end

        // Two-cycle imem latency
        lat_lo = 2; lat_hi = 2;
        do_reset();
        tick();
        chk("t2_busy0",  32'(fetch_busy), 32'd1);
        chk("t2_valid0", 32'(IF_ID_valid), 32'd0);
        tick();
        chk("t2_busy1",  32'(fetch_busy), 32'd1);
        chk("t2_valid1", 32'(IF_ID_valid), 32'd0);
        tick();
        chk("t2_busy2",  32'(fetch_busy), 32'd0);
        chk("t2_valid2", 32'(IF_ID_valid), 32'd0);
        tick();
        chk("t2_valid3", 32'(IF_ID_valid), 32'd1);
        chk("t2_pc4",    IF_ID_pc_plus4, 32'h4);
        chk("t2_instr",  IF_ID_instr, 32'h100);

        // Ack for addr 8 during a 3-cycle stall goes to the hold buffer
        lat_lo = 0; lat_hi = 0;
        do_reset();
        tick(); tick(); tick();
        chk("t3_addr8", bus.imem_addr, 32'h8);
        chk("t3_ack8",  32'(bus.imem_ack), 32'd1);
        pc_ld = 1'b0; IF_ID_write = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3_hold_req", 32'(bus.imem_req), 32'd0);
            chk("t3_hold_pc4", IF_ID_pc_plus4, 32'h8);
            chk("t3_hold_ins", IF_ID_instr, 32'h104);
        end
        pc_ld = 1'b1; IF_ID_write = 1'b1;
        tick();
        chk("t3_rel_pc4",   IF_ID_pc_plus4, 32'hC);
        chk("t3_rel_instr", IF_ID_instr, 32'h108);
        chk("t3_rel_valid", 32'(IF_ID_valid), 32'd1);
        chk("t3_next_addr", bus.imem_addr, 32'hC);
        chk("t3_next_req",  32'(bus.imem_req), 32'd1);

        // Jump flush while addr 16 is outstanding
        man_mode = 1'b1; man_ack = 1'b1;
        do_reset();
        tick();
        repeat (4) tick();
        chk("t4_addr16", bus.imem_addr, 32'h10);
        man_ack = 1'b0; flush = 1'b1; jump = 1'b1; jump_target = 32'h40;
        tick();
        flush = 1'b0;
        chk("t4_kill_valid", 32'(IF_ID_valid), 32'd0);
        chk("t4_kill_instr", IF_ID_instr, 32'h0);
        chk("t4_drop_addr",  bus.imem_addr, 32'h10);
        chk("t4_drop_req",   32'(bus.imem_req), 32'd1);
        tick();
        chk("t4_drop_busy",  32'(fetch_busy), 32'd1);
        man_ack = 1'b1;
        tick();
        chk("t4_new_addr",   bus.imem_addr, 32'h40);
        chk("t4_discarded",  32'(IF_ID_valid), 32'd0);
        tick();
        chk("t4_tgt_valid",  32'(IF_ID_valid), 32'd1);
        chk("t4_tgt_pc4",    IF_ID_pc_plus4, 32'h44);
        chk("t4_tgt_instr",  IF_ID_instr, 32'h140);

        // Branch flush together with IF_ID_write=0: flush wins
        flush = 1'b1; jump = 1'b0; branch_target = 32'h80; IF_ID_write = 1'b0; pc_ld = 1'b0;
        tick();
        flush = 1'b0; IF_ID_write = 1'b1; pc_ld = 1'b1;
        chk("t5_kill_valid", 32'(IF_ID_valid), 32'd0);
        chk("t5_kill_instr", IF_ID_instr, 32'h0);
        chk("t5_addr",       bus.imem_addr, 32'h80);
        tick();
        chk("t5_pc4",        IF_ID_pc_plus4, 32'h84);

        // Reset while in DROP
        man_ack = 1'b0; flush = 1'b1; branch_target = 32'h200;
        tick();
        flush = 1'b0;
        chk("t6_drop_busy", 32'(fetch_busy), 32'd1);
        rst = 1'b0;
        tick();
        chk("t6_rst_valid", 32'(IF_ID_valid), 32'd0);
        chk("t6_rst_req",   32'(bus.imem_req), 32'd0);
        rst = 1'b1;
        tick();
        chk("t6_first_req",  32'(bus.imem_req), 32'd1);
        chk("t6_first_addr", bus.imem_addr, 32'h0);
        man_ack = 1'b1;
        tick();
        chk("t6_first_pc4",  IF_ID_pc_plus4, 32'h4);

        // Address wrap at the top of memory
        flush = 1'b1; branch_target = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0;
        chk("wrap_addr",  bus.imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc4",   IF_ID_pc_plus4, 32'h0);
        chk("wrap_instr", IF_ID_instr, 32'h0000_00FC);
        chk("wrap_next",  bus.imem_addr, 32'h0);

        // Random stalls, flushes and latencies against an instruction-stream model
        man_mode = 1'b0; lat_lo = 0; lat_hi = 2;
        do_reset();
        exp_next = 32'h0; deliveries = 0;
        snap_instr = IF_ID_instr; snap_pc4 = IF_ID_pc_plus4; snap_valid = IF_ID_valid;
        p_req = 1'b0; p_ack = 1'b0; p_addr = 32'h0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            IF_ID_write   = ($urandom_range(0, 99) >= 25);
            pc_ld         = IF_ID_write;
            flush         = ($urandom_range(0, 99) < 8);
            jump          = 1'($urandom_range(0, 1));
            branch_target = 32'($urandom_range(0, 1023)) << 2;
            jump_target   = 32'($urandom_range(0, 1023)) << 2;
            a_flush = flush; a_write = IF_ID_write;
            a_tgt   = jump ? jump_target : branch_target;
            tick();
            if (a_flush) begin
                chk("rnd_flush_valid", 32'(IF_ID_valid), 32'd0);
                chk("rnd_flush_instr", IF_ID_instr, 32'h0);
                exp_next = a_tgt;
            end else if (!a_write) begin
                chk("rnd_stall_instr", IF_ID_instr, snap_instr);
                chk("rnd_stall_pc4",   IF_ID_pc_plus4, snap_pc4);
                chk("rnd_stall_valid", 32'(IF_ID_valid), 32'(snap_valid));
            end else if (IF_ID_valid) begin
                chk("rnd_pc4",   IF_ID_pc_plus4, exp_next + 32'd4);
                chk("rnd_instr", IF_ID_instr, mem_word(exp_next));
                exp_next = exp_next + 32'd4;
                deliveries++;
            end else begin
                chk("rnd_bubble_instr", IF_ID_instr, 32'h0);
            end
            if (p_req && !p_ack && bus.imem_req)
                chk("rnd_addr_stable", bus.imem_addr, p_addr);
            p_req = bus.imem_req; p_ack = bus.imem_ack; p_addr = bus.imem_addr;
            snap_instr = IF_ID_instr; snap_pc4 = IF_ID_pc_plus4; snap_valid = IF_ID_valid;
        end
        flush = 1'b0;
        chk("rnd_liveness", 32'(deliveries >= 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
